ahb_slave_mem: RTL and testbench

AHB-Lite responder that terminates transfers from the GP-engine AHB master into a local word-addressed SRAM-style register array. It samples address and control in the address phase and completes the data phase after a configurable number of wait states. It returns a two-cycle ERROR response for illegal accesses. It serves as the default memory/peripheral target on the AHB segment and as the bus-functional responder for master verification.

---
 rtl/ahb_slave_mem.sv | 239 +++++++++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem
// ---------------------------------------------------------------------------
// AHB-Lite responder backed by a local word-addressed memory array. This is
// the default memory/peripheral target on the GP-engine AHB segment and the
// bus-functional responder used when verifying the master.
//
// Each transfer is qualified in the address phase (hsel & htrans & hready).
// Legal transfers complete after WAIT_STATES low-ready cycles. Illegal ones
// (out of range, hsize > word, misaligned) receive the standard two-cycle
// ERROR response and never touch the array.
//
// Ports
//   i_clk_ahb    : AHB clock
//   i_rstn_ahb   : asynchronous active-low reset
//   i_hsel       : slave select from the address decoder
//   i_htrans     : 0 IDLE, 1 NONSEQ
//   i_hwrite     : 1 write, 0 read
//   i_hsize      : 0 byte, 1 halfword, 2 word (larger values are illegal)
//   i_haddr      : byte address
//   i_hwdata     : write data, valid in the data phase
//   i_hready     : bus-level ready; the address phase is taken only when high
//   o_hreadyout  : slave ready, low inserts a wait state
//   o_hresp      : 0 OKAY, 1 ERROR
//   o_hrdata     : read data, non-zero only in a read's final data cycle
// ---------------------------------------------------------------------------
module ahb_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  i_clk_ahb,
  input  logic                  i_rstn_ahb,
  input  logic                  i_hsel,
  input  logic                  i_htrans,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata
);

  // The byte-lane logic assumes a 32-bit bus: four lanes of eight bits.
  localparam int LANES = 4;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [3:0]        wait_cnt_reg;
  logic [3:0]        wait_cnt_next;

  // Address-phase information captured on accept.
  logic [IDX_W-1:0]  word_idx_reg;
  logic [1:0]        lane_reg;
  logic [1:0]        size_reg;
  logic              write_reg;

  logic [DATA_WIDTH-1:0] rdata_reg;

  // Combinational control.
  logic              accept;
  logic              legal;
  logic              out_of_range;
  logic              size_bad;
  logic              misaligned;
  logic              capture;
  logic              load_rd;
  logic [IDX_W-1:0]  rd_idx;
  logic              hreadyout_comb;
  logic              hresp_comb;
  logic [LANES-1:0]  byte_en;
  logic              wr_commit;
  logic [DATA_WIDTH-1:0] rd_word_fwd;

  // -------------------------------------------------------------------------
  // Address-phase qualification and legality
  // -------------------------------------------------------------------------
  assign accept = i_hsel & i_htrans & i_hready;

  // Any set bit above the word index means the word index is >= DEPTH
  // (DEPTH is a power of two).
  assign out_of_range = |i_haddr[ADDR_WIDTH-1:IDX_W+2];
  assign size_bad     = (i_hsize > 3'd2);
  assign misaligned   = ((i_hsize == 3'd1) && i_haddr[0]) ||
                        ((i_hsize == 3'd2) && (i_haddr[1:0] != 2'b00));
  assign legal        = ~out_of_range & ~size_bad & ~misaligned;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    hreadyout_comb = 1'b1;
    hresp_comb     = 1'b0;
    capture        = 1'b0;
    load_rd        = 1'b0;
    rd_idx         = word_idx_reg;

    case (state_reg)
      // IDLE, DATA and ERR2 all end with hreadyout high, so each of them
      // can take a new (possibly pipelined) address phase.
      ST_IDLE, ST_DATA, ST_ERR2: begin
        hreadyout_comb = 1'b1;
        hresp_comb     = (state_reg == ST_ERR2);
        if (accept) begin
          capture = 1'b1;
          if (!legal) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = 4'(WAIT_STATES - 1);
          end else begin
            state_next = ST_DATA;
            load_rd    = ~i_hwrite;
            rd_idx     = i_haddr[IDX_W+1:2];
          end
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_WAIT: begin
        hreadyout_comb = 1'b0;
        if (wait_cnt_reg == 4'd0) begin
          state_next = ST_DATA;
          load_rd    = ~write_reg;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end

      ST_ERR1: begin
        hreadyout_comb = 1'b0;
        hresp_comb     = 1'b1;
        state_next     = ST_ERR2;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_hreadyout = hreadyout_comb;
  assign o_hresp     = hresp_comb;

  // -------------------------------------------------------------------------
  // Captured address-phase control
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      word_idx_reg <= '0;
      lane_reg     <= 2'b00;
      size_reg     <= 2'b00;
      write_reg    <= 1'b0;
    end else if (capture) begin
      word_idx_reg <= i_haddr[IDX_W+1:2];
      lane_reg     <= i_haddr[1:0];
      size_reg     <= i_hsize[1:0];
      write_reg    <= i_hwrite;
    end
  end

  // Little-endian byte enables from the captured size and low address bits.
  // Only legal transfers reach DATA, so size_reg is 0, 1 or 2 there.
  always_comb begin
    byte_en = 4'b1111;
    case (size_reg)
      2'd0:    byte_en = 4'b0001 << lane_reg;
      2'd1:    byte_en = lane_reg[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Writes commit at the edge that closes the write data phase. A reset
  // forces the state to IDLE asynchronously, which drops a pending write.
  assign wr_commit = (state_reg == ST_DATA) & write_reg;

  // -------------------------------------------------------------------------
  // Memory array, one byte-wide bank per lane
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];

      always_ff @(posedge i_clk_ahb) begin
        if (wr_commit && byte_en[gi]) begin
          mem_lane[word_idx_reg] <= i_hwdata[gi*8 +: 8];
        end
      end

      // A read accepted while a write to the same word is closing must see
      // the new bytes, so forward them past the array.
      assign rd_word_fwd[gi*8 +: 8] =
        (wr_commit && byte_en[gi] && (word_idx_reg == rd_idx)) ?
        i_hwdata[gi*8 +: 8] : mem_lane[rd_idx];
    end
  endgenerate

  // Read data is registered on entry to a read DATA cycle and cleared on
  // every other edge, so o_hrdata is zero outside that single cycle.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      rdata_reg <= '0;
    end else if (load_rd) begin
      rdata_reg <= rd_word_fwd;
    end else begin
      rdata_reg <= '0;
    end
  end

  assign o_hrdata = rdata_reg;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed self-checking bench for ahb_slave_mem. Two instances are used:
// dut0 with no wait states and dut3 with three. Each slave's hreadyout is
// fed back as its own bus-level hready.
module tb_ahb_slave_mem;

  logic        clk;
  logic        rstn;
  logic        hsel0;
  logic        hsel3;
  logic        htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;

  logic        hreadyout0;
  logic        hresp0;
  logic [31:0] hrdata0;
  logic        hreadyout3;
  logic        hresp3;
  logic [31:0] hrdata3;

  int checks   = 0;
  int failures = 0;

  ahb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .i_clk_ahb  (clk),
    .i_rstn_ahb (rstn),
    .i_hsel     (hsel0),
    .i_htrans   (htrans),
    .i_hwrite   (hwrite),
    .i_hsize    (hsize),
    .i_haddr    (haddr),
    .i_hwdata   (hwdata),
    .i_hready   (hreadyout0),
    .o_hreadyout(hreadyout0),
    .o_hresp    (hresp0),
    .o_hrdata   (hrdata0)
  );

  ahb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) dut3 (
    .i_clk_ahb  (clk),
    .i_rstn_ahb (rstn),
    .i_hsel     (hsel3),
    .i_htrans   (htrans),
    .i_hwrite   (hwrite),
    .i_hsize    (hsize),
    .i_haddr    (haddr),
    .i_hwdata   (hwdata),
    .i_hready   (hreadyout3),
    .o_hreadyout(hreadyout3),
    .o_hresp    (hresp3),
    .o_hrdata   (hrdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete non-pipelined transfer. Entered just after a rising edge
  // with the target idle; returns just after the edge closing the data phase.
  task automatic xfer(input bit d3, input bit w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output int nw,
                      output logic r_first, output logic r_last);
    bit done;
    hsel0  = ~d3;
    hsel3  = d3;
    htrans = 1'b1;
    hwrite = w;
    hsize  = sz;
    haddr  = a;
    tick();
    hsel0   = 1'b0;
    hsel3   = 1'b0;
    htrans  = 1'b0;
    hwdata  = wd;
    nw      = 0;
    done    = 1'b0;
    rd      = 32'h0;
    r_first = 1'b0;
    r_last  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) r_first = d3 ? hresp3 : hresp0;
      if ((d3 ? hreadyout3 : hreadyout0) === 1'b1) begin
        rd     = d3 ? hrdata3 : hrdata0;
        r_last = d3 ? hresp3 : hresp0;
        done   = 1'b1;
        break;
      end
      nw++;
      @(posedge clk);
      #1;
    end
    chk("xfer_completes", {31'b0, done}, 32'h1);
    tick();
    hwdata = 32'h0;
  endtask

  logic [31:0] rd;
  int          nw;
  logic        rf;
  logic        rl;

  initial begin
    rstn   = 1'b0;
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = 1'b0;
    hwrite = 1'b0;
    hsize  = 3'd0;
    haddr  = 32'h0;
    hwdata = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hreadyout0", {31'b0, hreadyout0}, 32'h1);
    chk("rst_hresp0",     {31'b0, hresp0},     32'h0);
    chk("rst_hrdata0",    hrdata0,             32'h0);
    chk("rst_hreadyout3", {31'b0, hreadyout3}, 32'h1);
    chk("rst_hrdata3",    hrdata3,             32'h0);
    $display("step reset: checked reset outputs");
    rstn = 1'b1;
    tick();

    // Back-to-back word write then read @0x10, no wait states
    hsel0 = 1'b1; htrans = 1'b1; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
    tick();
    hwrite = 1'b0; hwdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("b2b_wr_ready", {31'b0, hreadyout0}, 32'h1);
    tick();
    hsel0 = 1'b0; htrans = 1'b0; hwdata = 32'h0;
    @(negedge clk);
    chk("b2b_rd_ready", {31'b0, hreadyout0}, 32'h1);
    chk("b2b_rd_resp",  {31'b0, hresp0},     32'h0);
    chk("b2b_rd_data",  hrdata0,             32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("b2b_idle_data", hrdata0, 32'h0);
    $display("step b2b: write/read 0x10 data=0x%08h", 32'hDEADBEEF);
    tick();

    // Byte and halfword merges into word 0x10
    xfer(1'b0, 1'b1, 3'd2, 32'h10, 32'h11223344, rd, nw, rf, rl);
    xfer(1'b0, 1'b1, 3'd0, 32'h13, 32'hAA000000, rd, nw, rf, rl);
    chk("byte_wr_nowait", nw, 32'd0);
    xfer(1'b0, 1'b0, 3'd2, 32'h10, 32'h0, rd, nw, rf, rl);
    chk("byte_merge", rd, 32'hAA223344);
    chk("byte_rd_resp", {31'b0, rl}, 32'h0);
    $display("step byte: read 0x10 -> 0x%08h", rd);
    xfer(1'b0, 1'b1, 3'd1, 32'h10, 32'h0000BBCC, rd, nw, rf, rl);
    xfer(1'b0, 1'b0, 3'd2, 32'h10, 32'h0, rd, nw, rf, rl);
    chk("half_merge", rd, 32'hAA22BBCC);
    $display("step half: read 0x10 -> 0x%08h", rd);

    // Wait states on dut3
    xfer(1'b1, 1'b1, 3'd2, 32'h4, 32'hCAFEF00D, rd, nw, rf, rl);
    chk("ws3_wr_waits", nw, 32'd3);
    xfer(1'b1, 1'b0, 3'd2, 32'h4, 32'h0, rd, nw, rf, rl);
    chk("ws3_rd_waits", nw, 32'd3);
    chk("ws3_rd_data", rd, 32'hCAFEF00D);
    chk("ws3_rd_resp", {31'b0, rl}, 32'h0);
    $display("step ws3: read 0x4 waits=%0d data=0x%08h", nw, rd);

    // ERROR responses; word 0 must keep its contents
    xfer(1'b0, 1'b1, 3'd2, 32'h0, 32'h0BADF00D, rd, nw, rf, rl);
    xfer(1'b0, 1'b1, 3'd2, 32'h400, 32'h12345678, rd, nw, rf, rl);
    chk("err_range_waits", nw, 32'd1);
    chk("err_range_resp1", {31'b0, rf}, 32'h1);
    chk("err_range_resp2", {31'b0, rl}, 32'h1);
    xfer(1'b0, 1'b1, 3'd2, 32'h2, 32'hFFFFFFFF, rd, nw, rf, rl);
    chk("err_align_waits", nw, 32'd1);
    chk("err_align_resp", {30'b0, rf, rl}, 32'h3);
    xfer(1'b0, 1'b1, 3'd3, 32'h0, 32'hFFFFFFFF, rd, nw, rf, rl);
    chk("err_size_waits", nw, 32'd1);
    chk("err_size_resp", {30'b0, rf, rl}, 32'h3);
    xfer(1'b0, 1'b0, 3'd2, 32'h0, 32'h0, rd, nw, rf, rl);
    chk("err_no_write", rd, 32'h0BADF00D);
    $display("step err: word 0 after errors -> 0x%08h", rd);

    // Pipelined write @0, read @0, write @8
    hsel0 = 1'b1; htrans = 1'b1; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h0;
    tick();
    hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h5A5A1234;
    @(negedge clk);
    chk("pipe_wr0_ready", {31'b0, hreadyout0}, 32'h1);
    chk("pipe_wr0_resp",  {31'b0, hresp0},     32'h0);
    tick();
    hwrite = 1'b1; haddr = 32'h8; hwdata = 32'h0;
    @(negedge clk);
    chk("pipe_rd_ready", {31'b0, hreadyout0}, 32'h1);
    chk("pipe_rd_data",  hrdata0,             32'h5A5A1234);
    tick();
    hsel0 = 1'b0; htrans = 1'b0; hwdata = 32'h600DCAFE;
    @(negedge clk);
    chk("pipe_wr8_ready", {31'b0, hreadyout0}, 32'h1);
    chk("pipe_wr8_resp",  {31'b0, hresp0},     32'h0);
    chk("pipe_wr8_rdata", hrdata0,             32'h0);
    tick();
    hwdata = 32'h0;
    xfer(1'b0, 1'b0, 3'd2, 32'h8, 32'h0, rd, nw, rf, rl);
    chk("pipe_wr8_commit", rd, 32'h600DCAFE);
    $display("step pipe: read 0x8 -> 0x%08h", rd);

    // Reset during the WAIT of a write on dut3
    xfer(1'b1, 1'b1, 3'd2, 32'h8, 32'h01020304, rd, nw, rf, rl);
    hsel3 = 1'b1; htrans = 1'b1; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h8;
    tick();
    hsel3 = 1'b0; htrans = 1'b0; hwdata = 32'hFFFF0000;
    @(negedge clk);
    chk("rstw_in_wait", {31'b0, hreadyout3}, 32'h0);
    #1 rstn = 1'b0;
    #1;
    chk("rstw_hreadyout", {31'b0, hreadyout3}, 32'h1);
    chk("rstw_hresp",     {31'b0, hresp3},     32'h0);
    chk("rstw_hrdata",    hrdata3,             32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    hwdata = 32'h0;
    tick();
    xfer(1'b1, 1'b0, 3'd2, 32'h8, 32'h0, rd, nw, rf, rl);
    chk("rstw_prior_data", rd, 32'h01020304);
    $display("step rstw: read 0x8 after reset -> 0x%08h", rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
